// File: rtl/msb_pkg.sv
// Shared constants and FSM state type for the MSB word builder.
package msb_pkg;

  localparam int MSB_WIDTH = 32;
  localparam int MSB_POS_W = 6;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/msb_pos_decode.sv
// Combinational 1-based position to one-hot mask expander.
// Position 0 and positions above WIDTH produce an all-zero mask; the latter
// also raise out_of_range.
module msb_pos_decode
  import msb_pkg::*;
#(
  parameter int WIDTH = MSB_WIDTH,
  parameter int POS_W = MSB_POS_W
) (
  input  logic [POS_W-1:0] pos,
  output logic [WIDTH-1:0] mask,
  output logic             out_of_range
);

  // Expand the position into a single set bit at pos-1
  always_comb begin
    mask         = '0;
    out_of_range = (pos > POS_W'(WIDTH));
    if ((pos != '0) && !out_of_range) begin
      mask = {{(WIDTH-1){1'b0}}, 1'b1} << (pos - POS_W'(1));
    end
  end

endmodule

// File: rtl/msb_word_builder.sv
// Rebuilds a word from a stream of 1-based MSB positions (one per beat).
// Beats are ORed into an accumulator; a beat flagged last moves the block to
// HOLD, where the finished word waits for out_ready.
// Optional feature macro: MSB_BUILD_ORDER_CHECK_EN enables the strictly
// descending order check that drives ord_err; otherwise ord_err is 0.
module msb_word_builder
  import msb_pkg::*;
#(
  parameter int WIDTH = MSB_WIDTH,
  parameter int POS_W = MSB_POS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] input_pos,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_num,
  output logic [POS_W-1:0] output_cnt,
  output logic             range_err,
  output logic             ord_err
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q;
  logic [POS_W-1:0] cnt_q;
  logic             rerr_q;
  logic [WIDTH-1:0] pos_mask;
  logic             pos_oor;
  logic             beat_fire;
  logic             word_drain;

  msb_pos_decode #(
    .WIDTH (WIDTH),
    .POS_W (POS_W)
  ) u_pos_decode (
    .pos          (input_pos),
    .mask         (pos_mask),
    .out_of_range (pos_oor)
  );

  assign beat_fire  = in_valid && (state_q == COLLECT);
  assign word_drain = out_ready && (state_q == HOLD);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // Next-state: close the word on a last beat, reopen on drain
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (beat_fire && in_last) state_d = HOLD;
      HOLD:    if (out_ready)            state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Accumulator, saturating beat count and sticky range flag
  always_ff @(posedge clk) begin
    if (!rst_n || word_drain) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      rerr_q <= 1'b0;
    end else if (beat_fire) begin
      acc_q <= acc_q | pos_mask;
      if (cnt_q != '1) cnt_q <= cnt_q + POS_W'(1);
      if (pos_oor) rerr_q <= 1'b1;
    end
  end

`ifdef MSB_BUILD_ORDER_CHECK_EN
  logic [POS_W-1:0] last_pos_q;
  logic             oerr_q;
  logic             pos_tracked;
  logic             ord_viol;

  // Only in-range nonzero positions take part in the order check
  assign pos_tracked = (input_pos != '0) && !pos_oor;
  assign ord_viol    = pos_tracked && (last_pos_q != '0) && (input_pos >= last_pos_q);

  // Track the last tracked position and flag any non-descending beat
  always_ff @(posedge clk) begin
    if (!rst_n || word_drain) begin
      last_pos_q <= '0;
      oerr_q     <= 1'b0;
    end else if (beat_fire) begin
      if (ord_viol)    oerr_q     <= 1'b1;
      if (pos_tracked) last_pos_q <= input_pos;
    end
  end

  assign ord_err = oerr_q;
`else
  assign ord_err = 1'b0;
`endif

  assign in_ready   = (state_q == COLLECT);
  assign out_valid  = (state_q == HOLD);
  assign output_num = acc_q;
  assign output_cnt = cnt_q;
  assign range_err  = rerr_q;

endmodule

// File: tb/tb_msb_word_builder.sv
// Self-checking bench for msb_word_builder: directed scenarios plus random
// words decomposed MSB-first by a reference model.
module tb_msb_word_builder;

  localparam int W  = 32;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] input_pos;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  output_num;
  logic [PW-1:0] output_cnt;
  logic          range_err;
  logic          ord_err;

  int n_tests = 0;
  int n_fail  = 0;

  int           q_pos[$];
  logic [W-1:0] exp_word;
  int           exp_cnt;
  logic         exp_rerr;
  logic         exp_oerr;

  always #5 clk = ~clk;

  msb_word_builder #(.WIDTH(W), .POS_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .input_pos  (input_pos),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .output_num (output_num),
    .output_cnt (output_cnt),
    .range_err  (range_err),
    .ord_err    (ord_err)
  );

  // Reference: expected results of the beat list in q_pos
  function automatic void model();
    int prev;
    exp_word = '0;
    exp_rerr = 1'b0;
    exp_oerr = 1'b0;
    prev     = 0;
    foreach (q_pos[i]) begin
      if (q_pos[i] > W) exp_rerr = 1'b1;
      else if (q_pos[i] != 0) begin
        exp_word = exp_word | (W'(1) << (q_pos[i] - 1));
`ifdef MSB_BUILD_ORDER_CHECK_EN
        if (prev != 0 && q_pos[i] >= prev) exp_oerr = 1'b1;
`endif
        prev = q_pos[i];
      end
    end
    exp_cnt = (q_pos.size() > 63) ? 63 : q_pos.size();
  endfunction

  // Feed q_pos with random input gaps; last flag on the final beat if asked
  task automatic drive_word(input int gap_max, input bit set_last);
    int guard;
    foreach (q_pos[i]) begin
      @(negedge clk);
      repeat ($urandom_range(gap_max, 0)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid  = 1'b1;
      input_pos = PW'(q_pos[i]);
      in_last   = set_last && (i == q_pos.size() - 1);
      guard = 0;
      while (!in_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) begin
        n_tests++;
        n_fail++;
        $display("FAIL drive_timeout: in_ready stuck at %0b, required 1", in_ready);
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for the word, check it, hold it for 'stall' cycles, drain, check clear
  task automatic collect(input int stall, input string name);
    int guard;
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_out_valid: got %0b, required 1", name, out_valid);
    end
    n_tests++;
    if (output_num !== exp_word || output_cnt !== PW'(exp_cnt) ||
        range_err !== exp_rerr || ord_err !== exp_oerr || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_word: got num=%h cnt=%0d rerr=%0b oerr=%0b rdy=%0b, required num=%h cnt=%0d rerr=%0b oerr=%0b rdy=0",
               name, output_num, output_cnt, range_err, ord_err, in_ready,
               exp_word, exp_cnt, exp_rerr, exp_oerr);
    end
    // Offer a beat while held: it must not be absorbed
    for (int s = 0; s < stall; s++) begin
      in_valid  = 1'b1;
      input_pos = PW'(1);
      in_last   = 1'b1;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || output_num !== exp_word ||
          output_cnt !== PW'(exp_cnt) || range_err !== exp_rerr || ord_err !== exp_oerr) begin
        n_fail++;
        $display("FAIL %s_hold_stable: got vld=%0b rdy=%0b num=%h cnt=%0d, required vld=1 rdy=0 num=%h cnt=%0d",
                 name, out_valid, in_ready, output_num, output_cnt, exp_word, exp_cnt);
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || output_num !== '0 || output_cnt !== '0 ||
        range_err !== 1'b0 || ord_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: got vld=%0b rdy=%0b num=%h cnt=%0d rerr=%0b oerr=%0b, required vld=0 rdy=1 num=0 cnt=0 errs=0",
               name, out_valid, in_ready, output_num, output_cnt, range_err, ord_err);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || output_num !== '0 || output_cnt !== '0 ||
        range_err !== 1'b0 || ord_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got rdy=%0b vld=%0b num=%h cnt=%0d rerr=%0b oerr=%0b, required rdy=1 vld=0 num=0 cnt=0 errs=0",
               name, in_ready, out_valid, output_num, output_cnt, range_err, ord_err);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    input_pos = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_values("reset_values");
  endtask

  task automatic test_basic();
    q_pos = '{32, 16, 1};
    drive_word(0, 1'b1);
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: out_valid=%0b one cycle after last beat, required 1", out_valid);
    end
    exp_word = 32'h8000_8001;
    exp_cnt  = 3;
    exp_rerr = 1'b0;
    exp_oerr = 1'b0;
    collect(0, "basic");
  endtask

  task automatic test_single();
    q_pos = '{0};
    drive_word(0, 1'b1);
    exp_word = '0; exp_cnt = 1; exp_rerr = 1'b0; exp_oerr = 1'b0;
    collect(0, "single_zero");
    q_pos = '{33};
    drive_word(0, 1'b1);
    exp_word = '0; exp_cnt = 1; exp_rerr = 1'b1; exp_oerr = 1'b0;
    collect(0, "single_oor");
  endtask

  task automatic test_hold_stall();
    q_pos = '{8, 7, 6, 5};
    drive_word(1, 1'b1);
    exp_word = 32'h0000_00F0; exp_cnt = 4; exp_rerr = 1'b0; exp_oerr = 1'b0;
    collect(5, "hold_stall");
    q_pos = '{3};
    drive_word(0, 1'b1);
    exp_word = 32'h0000_0004; exp_cnt = 1; exp_rerr = 1'b0; exp_oerr = 1'b0;
    collect(0, "after_drain");
  endtask

  task automatic test_order();
    q_pos = '{5, 5, 9};
    drive_word(0, 1'b1);
    exp_word = 32'h0000_0110; exp_cnt = 3; exp_rerr = 1'b0;
`ifdef MSB_BUILD_ORDER_CHECK_EN
    exp_oerr = 1'b1;
`else
    exp_oerr = 1'b0;
`endif
    collect(0, "order");
    q_pos = '{20, 0, 40, 4};
    drive_word(0, 1'b1);
    exp_word = 32'h0008_0008; exp_cnt = 4; exp_rerr = 1'b1; exp_oerr = 1'b0;
    collect(0, "order_excluded");
  endtask

  task automatic test_saturation();
    q_pos.delete();
    for (int i = 0; i < 70; i++) q_pos.push_back((i % 3 == 0) ? 7 : 0);
    model();
    drive_word(0, 1'b1);
    exp_word = 32'h0000_0040; exp_cnt = 63;
    collect(0, "count_sat");
  endtask

  task automatic test_reset_midword();
    q_pos = '{10, 3};
    drive_word(0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_values("midword_reset");
    q_pos = '{2};
    drive_word(0, 1'b1);
    exp_word = 32'h0000_0002; exp_cnt = 1; exp_rerr = 1'b0; exp_oerr = 1'b0;
    collect(0, "post_reset");
    q_pos = '{6};
    drive_word(0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_values("hold_reset");
  endtask

  task automatic test_random();
    logic [W-1:0] w, rem;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(3, 0))
        0:       w = '0;
        1:       w = $urandom & $urandom & $urandom;
        default: w = $urandom;
      endcase
      q_pos.delete();
      rem = w;
      if (rem == '0) q_pos.push_back(0);
      while (rem != '0) begin
        for (int b = W - 1; b >= 0; b--) begin
          if (rem[b]) begin
            q_pos.push_back(b + 1);
            rem[b] = 1'b0;
            break;
          end
        end
      end
      model();
      drive_word(2, 1'b1);
      n_tests++;
      if (exp_word !== w) begin
        n_fail++;
        $display("FAIL rand_model_%0d: rebuilt %h, required %h", n, exp_word, w);
      end
      collect($urandom_range(3, 0), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_hold_stall();
    test_order();
    test_saturation();
    test_reset_midword();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/msb_word_builder.md
# msb_word_builder

Rebuilds a 32-bit word from a stream of 1-based MSB positions, one position per beat. This is the decode direction of the `msb_32bit` leading-one encoder: each beat ORs bit `pos-1` into an accumulator, and a beat marked last releases the finished word. It sits downstream of a position-producing stage, for example a loop that repeatedly strips the MSB of a word. Valid/ready handshakes on both sides let it absorb backpressure.

## Interface
Parameters:
- `WIDTH`, 32: width of the rebuilt word.
- `POS_W`, 6: position width; equals clog2(WIDTH)+1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  position beat valid.
- `in_ready`  out  1  builder can accept a beat.
- `input_pos`  in  POS_W  1-based bit position; 0 means "no bit", matching the encoder's zero-input code.
- `in_last`  in  1  this beat closes the word.
- `out_valid`  out  1  `output_num` holds a finished word.
- `out_ready`  in  1  consumer accepts the word.
- `output_num`  out  WIDTH  rebuilt word.
- `output_cnt`  out  POS_W  number of beats accepted for this word, saturating at 2^POS_W-1.
- `range_err`  out  1  sticky per word: some beat had `input_pos` > WIDTH.
- `ord_err`  out  1  sticky per word: order violation (see Configuration).

## Operation
- States: COLLECT and HOLD.
- COLLECT:
  - `in_ready`=1.
  - On a handshake (`in_valid`&&`in_ready`):
    - pos in 1..WIDTH: accumulator |= 1<<(pos-1).
    - pos 0: no bit is set.
    - pos > WIDTH: no bit is set and `range_err` is set.
  - `output_cnt` increments on every accepted beat.
  - If `in_last`=1 on the handshake, the state goes to HOLD.
- HOLD:
  - `in_ready`=0, `out_valid`=1.
  - `output_num`, `output_cnt` and both error flags are stable.
  - On `out_ready`=1: the accumulator, count and error flags clear, and the state returns to COLLECT.
- Duplicate positions are idempotent in the word; each duplicate still counts as a beat.
- A word made only of pos-0 beats outputs 0.
- Count width rule: `output_cnt` saturates and never wraps.
- Reset (any cycle, including mid-word or during HOLD): the state returns to COLLECT and the partial word is discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `output_num`=0, `output_cnt`=0, `range_err`=0, `ord_err`=0.
- Throughput is one beat per cycle in COLLECT.
- Latency: if the last beat is accepted at edge N, `out_valid`=1 after edge N, and `output_num` includes that beat.
- A word drained at edge M gives `in_ready`=1 after edge M. There is one bubble cycle per word; no bypass.
- All outputs come from registers. `in_ready` is a function of state only.
- `in_valid` without `in_ready` leaves no state change. The source must hold its beat until it is accepted.

## Configuration
Macro: `MSB_BUILD_ORDER_CHECK_EN`.
- Defined:
  - The block tracks the last nonzero position accepted in the current word.
  - A nonzero pos that is not strictly less than that tracked position sets `ord_err`. This covers duplicates and ascending order.
  - The bit is still ORed in.
  - pos 0 and out-of-range positions are excluded from the check.
- Not defined: the tracking register is absent and `ord_err` is tied to 0. The port list is the same either way.

## Structure
- Shared package `msb_pkg`: `WIDTH` and `POS_W` constants, plus the state enum (COLLECT, HOLD).
- Sub-module `msb_pos_decode`: combinational pos to one-hot, with zero output for pos 0 or pos > WIDTH, and an out-of-range flag. It is reused wherever a position must be expanded into a mask.

## Test plan
- Reset, then beats 32, 16, 1 (last), `out_ready`=1: the word is 0x8000_8001 with `output_cnt`=3 and no errors. `out_valid` rises the cycle after the last beat.
- Single beat 0 (last): `output_num`=0, `output_cnt`=1. Single beat 33 (last): `output_num`=0, `range_err`=1.
- Word 0x0000_00F0 accepted, `out_ready` held 0 for 5 cycles: `in_ready`=0 and the output is stable throughout. After the drain, the next word's accumulator starts at 0.
- Beats 5, 5, 9 (last), macro defined: `output_num`=0x0000_0110 and `ord_err`=1. Same beats without the macro: same word, `ord_err`=0.
- `rst_n` low for one cycle after beats 10 and 3: all outputs return to their reset values. Then beat 2 (last) produces 0x0000_0002 with `output_cnt`=1.
- Random 32-bit words are decomposed MSB-first by a reference model into positions, with random stalls on both sides: every rebuilt word equals the original.
